bcd_reaction_counter: RTL
=========================

# bcd_reaction_counter

Generates the four-digit BCD reaction-time count and the best (lowest) time for the seven-segment display path. The block runs the game state machine: idle, counting, result and overflow. Its `state`, current digits and best-time digits connect straight to the existing display decoder, which shows the best time in state A and the live count in every other state. The count resolution is 1 ms and the range is 0.000–9.999 s.

## Interface

- `ST_A`, 0: idle; the display shows the best time.
- `ST_B`, 1: counting.
- `ST_C`, 2: stopped; the display shows the result.
- `ST_D`, 3: overflow; the display shows 9.999.
- `Clk` input, 1 bit: system clock. One clock domain only.
- `Resetn` input, 1 bit: reset, synchronous and active-low.
- `tick` input, 1 bit: 1 kHz enable, a single `Clk`-wide pulse.
- `start` input, 1 bit: level-sampled start/advance request.
- `stop` input, 1 bit: level-sampled stop request.
- `state` output, 2 bits: current FSM state, encoded as A..D.
- `S`, `tS`, `hS`, `mS` outputs, 4 bits each: current count digits (seconds, tenths, hundredths, ms).
- `h_S`, `h_tS`, `h_hS`, `h_mS` outputs, 4 bits each: best-time digits.

## Operation

- On reset (`Resetn`=0 at a `Clk` edge):
  - state = A
  - `S`/`tS`/`hS`/`mS` = 0
  - best time = 9.999 (means "no score yet")
- The count is a 4-decade BCD chain:
  - `mS` increments on each `tick` in state B.
  - A decade that wraps from 9 to 0 carries into the next decade on the same edge.
  - Digits never hold values above 9.
- State transitions, evaluated on each `Clk` edge:
  - A, `start`=1 → B. Count cleared to 0.000 on the same edge.
  - B, `stop`=1 → C. Count freezes. `stop` has priority over a coincident `tick`, so that tick is dropped.
  - B, `tick` while count = 9.999 → D. Count stays at 9.999 (no wrap to 0.000).
  - C, `start`=1 → A. Count holds.
  - D, `start`=1 → A. Count holds.
  - All other input combinations: stay in the current state.
- Ignored inputs:
  - `stop` in states A, C and D.
  - `start` in state B.
  - `tick` outside state B.
- Best-time update:
  - Happens on the first edge after entering C, while the block is in C.
  - If count < best, best ← count. The comparison is a 16-bit unsigned compare of the digits packed as {S,tS,hS,mS}; this is valid because every digit is BCD.
  - Equal times do not update the best time.
  - The update is a single event per visit to C.
  - D never updates the best time.
- Best time persists across games and is cleared only by reset.

## Timing

- All outputs are registered. There is no combinational path from input to output.
- `start` in A: the next edge gives `state`=B and count 0.000. The first increment comes on the next `tick` after that edge.
- `stop` in B: `state`=C and the count is frozen on the same edge. The best-time digits change one edge later, if the new time is better.
- `tick` latency: the count changes on the edge that samples `tick`=1. A full carry ripple (e.g. 0.999 → 1.000) completes in that one edge.
- Overflow: the edge that samples `tick` at 9.999 moves `state` to D. The digits stay 9,9,9,9.
- Reset mid-count: reset takes effect on the next edge and overrides `start`, `stop` and `tick`. The best time is also reset to 9.999.
- Inputs are assumed synchronous to `Clk`. Debouncing and synchronisation are done upstream.

## Structure

- Shared package holds:
  - state encodings `ST_A`..`ST_D`
  - BCD digit width (4)
  - max digit value (9)
  - "no score" constant (9.999)
- Sub-module `bcd_digit` is instantiated ×4:
  - Inputs: `Clk`, `Resetn`, `clr`, `en`.
  - Outputs: `q`[3:0], `carry` (= `en` & `q`==9).
  - Chained through `carry`→`en`.
- The top level contains the FSM, saturation detect, best-time register and comparator.

## Test plan

- Reset, then idle: `state`=0, count 0.000, best 9.999; `tick`s while in A leave the count at 0.000.
- `start`, 1234 ticks, `stop`: `state`=2, count 1.234. One edge later best = 1.234. `start`: `state`=0, best digits 1,2,3,4.
- Second game with 1500 ticks: best stays 1.234. Third game with 0987 ticks: best = 0.987. A game equal to the best leaves it unchanged.
- Carry chain: 999 ticks gives 0.999; the next tick gives 1.000 in a single edge.
- Overflow: 9999 ticks gives 9.999 with `state`=1. One more tick gives `state`=3 and 9.999 held; the best is not updated; `start` gives `state`=0.
- Edge cases:
  - `stop` and `tick` on the same edge at 0.041: count stays 0.041.
  - `Resetn` low during counting at 0.500: `state`=0, count 0.000, best 9.999 on the next edge.

Source files
------------

// File: rtl/bcd_reaction_counter_pkg.sv
// Shared definitions for the BCD reaction-time counter: state encodings,
// digit geometry and the "no score yet" best-time value.
package bcd_reaction_counter_pkg;

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } state_t;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;
    // 9.999 packed as {S,tS,hS,mS}; doubles as the saturation value of the count
    localparam logic [15:0] NO_SCORE  = 16'h9999;

endpackage

// File: rtl/bcd_reaction_counter_bcd_digit.sv
// One BCD decade: counts 0..9 when enabled, wraps to 0 and flags a carry
// on the same edge so decades can be chained through carry -> en.
module bcd_digit
    import bcd_reaction_counter_pkg::*;
(
    input  logic               Clk,
    input  logic               Resetn,
    input  logic               clr,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_r;

    // Decade register: clear wins over enable, wrap 9 -> 0
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (en) begin
            q_r <= (q_r == DIGIT_MAX) ? 4'd0 : (q_r + 4'd1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q     = q_r;
    assign carry = en & (q_r == DIGIT_MAX);

endmodule

// File: rtl/bcd_reaction_counter.sv
// Reaction-timer core: game FSM, four-decade BCD count with saturation at
// 9.999, and the best (lowest) time register feeding the display decoder.
module bcd_reaction_counter
    import bcd_reaction_counter_pkg::*;
(
    input  logic       Clk,
    input  logic       Resetn,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] state,
    output logic [3:0] S,
    output logic [3:0] tS,
    output logic [3:0] hS,
    output logic [3:0] mS,
    output logic [3:0] h_S,
    output logic [3:0] h_tS,
    output logic [3:0] h_hS,
    output logic [3:0] h_mS
);

    state_t        state_r;
    state_t        next_state_s;
    logic [15:0]   best_r;
    logic          best_pend_r;

    logic          clr_s;
    logic          cnt_en_s;
    logic          enter_c_s;
    logic          sat_s;
    logic [15:0]   count_s;

    logic [DIGIT_W-1:0] digit_q_s   [4];
    logic               digit_c_s   [4];
    logic               digit_en_s  [4];
    logic               msd_carry_unused_s;

    // Decade chain, least significant digit first
    assign digit_en_s[0] = cnt_en_s;
    assign digit_en_s[1] = digit_c_s[0];
    assign digit_en_s[2] = digit_c_s[1];
    assign digit_en_s[3] = digit_c_s[2];
    assign msd_carry_unused_s = digit_c_s[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            bcd_digit u_digit (
                .Clk    (Clk),
                .Resetn (Resetn),
                .clr    (clr_s),
                .en     (digit_en_s[gi]),
                .q      (digit_q_s[gi]),
                .carry  (digit_c_s[gi])
            );
        end
    endgenerate

    assign count_s = {digit_q_s[3], digit_q_s[2], digit_q_s[1], digit_q_s[0]};
    assign sat_s   = (count_s == NO_SCORE);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_r <= ST_A;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; stop beats a coincident tick in B
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_A: begin
                if (start) next_state_s = ST_B;
                else       next_state_s = ST_A;
            end
            ST_B: begin
                if (stop)               next_state_s = ST_C;
                else if (tick && sat_s) next_state_s = ST_D;
                else                    next_state_s = ST_B;
            end
            ST_C: begin
                if (start) next_state_s = ST_A;
                else       next_state_s = ST_C;
            end
            ST_D: begin
                if (start) next_state_s = ST_A;
                else       next_state_s = ST_D;
            end
            default: next_state_s = ST_A;
        endcase
    end

    // FSM outputs: count clear/enable and the "just entered C" strobe
    always_comb begin
        clr_s     = 1'b0;
        cnt_en_s  = 1'b0;
        enter_c_s = 1'b0;
        case (state_r)
            ST_A: begin
                clr_s = start;
            end
            ST_B: begin
                cnt_en_s  = tick & ~stop & ~sat_s;
                enter_c_s = stop;
            end
            ST_C: begin
                clr_s = 1'b0;
            end
            ST_D: begin
                clr_s = 1'b0;
            end
            default: begin
                clr_s = 1'b0;
            end
        endcase
    end

    // One-shot flag: the best-time compare runs on the first edge spent in C
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            best_pend_r <= 1'b0;
        end else begin
            best_pend_r <= enter_c_s;
        end
    end

    // Best-time register; packed BCD compares correctly as plain unsigned
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            best_r <= NO_SCORE;
        end else if (best_pend_r && (count_s < best_r)) begin
            best_r <= count_s;
        end else begin
            best_r <= best_r;
        end
    end

    assign state = state_r;
    assign S     = digit_q_s[3];
    assign tS    = digit_q_s[2];
    assign hS    = digit_q_s[1];
    assign mS    = digit_q_s[0];
    assign h_S   = best_r[15:12];
    assign h_tS  = best_r[11:8];
    assign h_hS  = best_r[7:4];
    assign h_mS  = best_r[3:0];

endmodule
